// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster outputs shared by the timing generator and the pixel layers
interface vga_timing_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       pix_tick;
  logic       line_start;
  logic       frame_start;
  modport master (output x, y, video_on, hsync, vsync, pix_tick, line_start, frame_start);
  modport slave  (input  x, y, video_on, hsync, vsync, pix_tick, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider plus h/v raster counters with aligned sync, blanking and line/frame pulses
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vga
);
  localparam int         DW       = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ON  = 1'(SYNC_POL);

  logic [DW-1:0] div;
  logic          tick;
  logic          x_wrap;
  logic          y_wrap;
  logic [9:0]    x_n;
  logic [9:0]    y_n;

  // Tick is combinational so it can lead the x change by one edge; forced low in reset.
  assign tick         = rst_n && div == DIV_LAST;
  assign vga.pix_tick = tick;
  assign x_wrap       = tick && vga.x == H_LAST;
  assign y_wrap       = x_wrap && vga.y == V_LAST;
  assign x_n          = tick ? (x_wrap ? '0 : vga.x + 10'd1) : vga.x;
  assign y_n          = x_wrap ? (y_wrap ? '0 : vga.y + 10'd1) : vga.y;

  // Clock divider: free-running modulo-CLK_DIV counter.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div <= '0;
    else        div <= div == DIV_LAST ? '0 : div + 1'b1;

  // Counters and all decoded outputs load from next-state values so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vga.x           <= '0;
      vga.y           <= '0;
      vga.video_on    <= 1'b0;
      vga.hsync       <= ~SYNC_ON;
      vga.vsync       <= ~SYNC_ON;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.x           <= x_n;
      vga.y           <= y_n;
      vga.video_on    <= x_n < H_ACT && y_n < V_ACT;
      vga.hsync       <= (x_n >= HS_ON && x_n < HS_OFF) ? SYNC_ON : ~SYNC_ON;
      vga.vsync       <= (y_n >= VS_ON && y_n < VS_OFF) ? SYNC_ON : ~SYNC_ON;
      vga.line_start  <= x_wrap;
      vga.frame_start <= y_wrap;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a shrunken raster for CLK_DIV=2 and CLK_DIV=1 builds
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3, VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if v2 ();
  vga_timing_gen_if v1 ();

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0))
    u2 (.clk(clk), .rst_n(rst_n), .vga(v2.master));
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0))
    u1 (.clk(clk), .rst_n(rst_n), .vga(v1.master));

  logic [24:0] o2, o1, e;
  assign o2 = {v2.x, v2.y, v2.video_on, v2.hsync, v2.vsync, v2.pix_tick, v2.line_start, v2.frame_start};
  assign o1 = {v1.x, v1.y, v1.video_on, v1.hsync, v1.vsync, v1.pix_tick, v1.line_start, v1.frame_start};

  int compared = 0, mismatched = 0, k = 0;
  logic [24:0] exp_q[$];

  // Closed-form reference: k edges since release, d clocks per pixel.
  function automatic logic [24:0] model(int kk, int d, bit in_rst);
    int t, pos, xx, yy;
    logic vo, hs, vs, pt, ls, fs;
    t   = kk / d;
    pos = t % (HT * VT);
    xx  = pos % HT;
    yy  = pos / HT;
    vo  = !in_rst && kk > 0 && xx < HA && yy < VA;
    hs  = !(xx >= HA + HF && xx < HA + HF + HS);
    vs  = !(yy >= VA + VF && yy < VA + VF + VS);
    pt  = !in_rst && (kk % d) == d - 1;
    ls  = !in_rst && kk > 0 && (kk % d) == 0 && xx == 0;
    fs  = ls && yy == 0;
    return {10'(xx), 10'(yy), vo, hs, vs, pt, ls, fs};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (o2 !== model(0, 2, 1)) begin mismatched++; $display("FAIL reset_hold_div2 got %h want %h", o2, model(0, 2, 1)); end
      compared++;
      if (o1 !== model(0, 1, 1)) begin mismatched++; $display("FAIL reset_hold_div1 got %h want %h", o1, model(0, 1, 1)); end
    end
    rst_n = 1'b1;
    k = 0;
    #1;
    compared++;
    if (o2 !== model(0, 2, 0)) begin mismatched++; $display("FAIL reset_release_div2 got %h want %h", o2, model(0, 2, 0)); end
    compared++;
    if (v1.pix_tick !== 1'b1) begin mismatched++; $display("FAIL reset_release_tick_div1 got %b want 1", v1.pix_tick); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); k++; exp_q.push_back(model(k, 2, 0));
      @(negedge clk); e = exp_q.pop_front(); compared++;
      if (o2 !== e) begin mismatched++; $display("FAIL reset_exit k=%0d got %h want %h", k, o2, e); end
    end
  endtask

  task automatic test_horizontal();
    int fall_k, last_ls;
    logic prev_hs;
    do_reset();
    fall_k = -1; last_ls = -1; prev_hs = 1'b1;
    for (int i = 0; i < 4 * HT + 10; i++) begin
      @(posedge clk); k++; exp_q.push_back(model(k, 2, 0));
      @(negedge clk); e = exp_q.pop_front(); compared++;
      if (o2 !== e) begin mismatched++; $display("FAIL horiz k=%0d got %h want %h", k, o2, e); end
      if (prev_hs && !v2.hsync) begin
        fall_k = k; compared++;
        if (v2.x !== 10'(HA + HF)) begin mismatched++; $display("FAIL hsync_start_x got %0d want %0d", v2.x, HA + HF); end
      end
      if (!prev_hs && v2.hsync && fall_k >= 0) begin
        compared++;
        if (k - fall_k !== 2 * HS) begin mismatched++; $display("FAIL hsync_width got %0d want %0d", k - fall_k, 2 * HS); end
      end
      if (v2.line_start) begin
        compared++;
        if (v2.x !== 10'd0) begin mismatched++; $display("FAIL line_start_x got %0d want 0", v2.x); end
        if (last_ls >= 0) begin
          compared++;
          if (k - last_ls !== 2 * HT) begin mismatched++; $display("FAIL line_period got %0d want %0d", k - last_ls, 2 * HT); end
        end
        last_ls = k;
      end
      prev_hs = v2.hsync;
    end
  endtask

  task automatic test_vertical();
    int fall_k, last_fs, n_fs, max_y;
    logic prev_vs;
    do_reset();
    fall_k = -1; last_fs = -1; n_fs = 0; max_y = 0; prev_vs = 1'b1;
    for (int i = 0; i < 4 * HT * VT + 20; i++) begin
      @(posedge clk); k++; exp_q.push_back(model(k, 2, 0));
      @(negedge clk); e = exp_q.pop_front(); compared++;
      if (o2 !== e) begin mismatched++; $display("FAIL vert k=%0d got %h want %h", k, o2, e); end
      if (int'(v2.y) > max_y) max_y = int'(v2.y);
      if (prev_vs && !v2.vsync) begin
        fall_k = k; compared++;
        if ({v2.x, v2.y} !== {10'd0, 10'(VA + VF)}) begin mismatched++; $display("FAIL vsync_start got x=%0d y=%0d want x=0 y=%0d", v2.x, v2.y, VA + VF); end
      end
      if (!prev_vs && v2.vsync && fall_k >= 0) begin
        compared++;
        if (k - fall_k !== 2 * HT * VS) begin mismatched++; $display("FAIL vsync_width got %0d want %0d", k - fall_k, 2 * HT * VS); end
      end
      if (v2.frame_start) begin
        n_fs++;
        compared++;
        if (k - last_fs !== 2 * HT * VT) begin mismatched++; $display("FAIL frame_period got %0d want %0d", k - last_fs, 2 * HT * VT); end
        last_fs = k;
      end
      if (i == 0) last_fs = 0;
      prev_vs = v2.vsync;
    end
    compared++;
    if (n_fs !== 2) begin mismatched++; $display("FAIL frame_count got %0d want 2", n_fs); end
    compared++;
    if (max_y !== VT - 1) begin mismatched++; $display("FAIL max_y got %0d want %0d", max_y, VT - 1); end
  endtask

  task automatic test_active_count();
    int cnt;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      @(posedge clk); k++; exp_q.push_back(model(k, 2, 0));
      @(negedge clk); e = exp_q.pop_front(); compared++;
      if (o2 !== e) begin mismatched++; $display("FAIL active k=%0d got %h want %h", k, o2, e); end
      if (v2.video_on) cnt++;
      if (v2.x == 10'(HA) || v2.y == 10'(VA)) begin
        compared++;
        if (v2.video_on !== 1'b0) begin mismatched++; $display("FAIL blank_edge x=%0d y=%0d got %b want 0", v2.x, v2.y, v2.video_on); end
      end
    end
    compared++;
    if (cnt !== 2 * HA * VA) begin mismatched++; $display("FAIL active_count got %0d want %0d", cnt, 2 * HA * VA); end
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    n = 0;
    while (!(v2.x == 10'd10 && v2.y == 10'd3) && n < 1000) begin
      @(posedge clk); k++; exp_q.push_back(model(k, 2, 0));
      @(negedge clk); e = exp_q.pop_front(); compared++; n++;
      if (o2 !== e) begin mismatched++; $display("FAIL mid_run k=%0d got %h want %h", k, o2, e); end
    end
    compared++;
    if (n >= 1000) begin mismatched++; $display("FAIL mid_reach got timeout want x=10 y=3"); end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (o2 !== model(0, 2, 1)) begin mismatched++; $display("FAIL mid_async got %h want %h", o2, model(0, 2, 1)); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk); compared++;
      if (o2 !== model(0, 2, 1)) begin mismatched++; $display("FAIL mid_hold got %h want %h", o2, model(0, 2, 1)); end
    end
    rst_n = 1'b1;
    k = 0;
    #1;
    compared++;
    if (o2 !== model(0, 2, 0)) begin mismatched++; $display("FAIL mid_release got %h want %h", o2, model(0, 2, 0)); end
    for (int i = 0; i < 3 * HT; i++) begin
      @(posedge clk); k++; exp_q.push_back(model(k, 2, 0));
      @(negedge clk); e = exp_q.pop_front(); compared++;
      if (o2 !== e) begin mismatched++; $display("FAIL mid_restart k=%0d got %h want %h", k, o2, e); end
    end
  endtask

  task automatic test_div1();
    int fall_k, last_ls, ticks;
    logic prev_hs;
    do_reset();
    fall_k = -1; last_ls = -1; ticks = 0; prev_hs = 1'b1;
    for (int i = 0; i < HT * VT + 25; i++) begin
      @(posedge clk); k++; exp_q.push_back(model(k, 1, 0));
      @(negedge clk); e = exp_q.pop_front(); compared++;
      if (o1 !== e) begin mismatched++; $display("FAIL div1 k=%0d got %h want %h", k, o1, e); end
      if (v1.pix_tick) ticks++;
      if (!prev_hs && v1.hsync && fall_k >= 0) begin
        compared++;
        if (k - fall_k !== HS) begin mismatched++; $display("FAIL div1_hsync_width got %0d want %0d", k - fall_k, HS); end
      end
      if (prev_hs && !v1.hsync) fall_k = k;
      if (v1.line_start) begin
        if (last_ls >= 0) begin
          compared++;
          if (k - last_ls !== HT) begin mismatched++; $display("FAIL div1_line_period got %0d want %0d", k - last_ls, HT); end
        end
        last_ls = k;
      end
      prev_hs = v1.hsync;
    end
    compared++;
    if (ticks !== HT * VT + 25) begin mismatched++; $display("FAIL div1_tick_count got %0d want %0d", ticks, HT * VT + 25); end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_active_count();
    test_mid_reset();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the VGA raster for the display pipeline. It divides the board clock down to a pixel-rate enable and runs the horizontal and vertical pixel counters. It drives hsync/vsync to the connector, and supplies the x/y coordinates and video_on that the text, HUD and sprite layers decode into pixel-on flags. It also provides frame/line pulses so game logic can update state once per frame.

## Interface
Parameters:
- CLK_DIV, 2: board clocks per pixel (≥1); 2 gives 25 MHz pixels from 50 MHz.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: asserted level of hsync/vsync (0 = active-low).

Ports:
- clk  in  1  board clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- x  out  10  horizontal count, 0..H_TOTAL-1 (H_TOTAL = sum of H_*, 800).
- y  out  10  vertical count, 0..V_TOTAL-1 (V_TOTAL = sum of V_*, 525).
- video_on  out  1  high when x < H_ACTIVE and y < V_ACTIVE.
- hsync  out  1  horizontal sync, level per SYNC_POL.
- vsync  out  1  vertical sync, level per SYNC_POL.
- pix_tick  out  1  one-clk pixel enable.
- line_start  out  1  one-clk pulse when x wraps to 0.
- frame_start  out  1  one-clk pulse when x and y both wrap to 0.

## Operation
- Divider counts 0..CLK_DIV-1 and wraps. pix_tick = (div == CLK_DIV-1), gated low while rst_n is low. With CLK_DIV=1, pix_tick is constantly 1 out of reset.
- x advances only on pix_tick cycles. At H_TOTAL-1, x wraps to 0 and y increments.
- At y = V_TOTAL-1 with the x wrap, y also wraps to 0.
- x and y always carry raw counts, including during blanking. Consumers gate with video_on.
- All outputs except pix_tick are registered. Their next values are decoded from the next counter values, so x, y, video_on, hsync and vsync change on the same clk edge and stay mutually aligned.
- hsync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), which is [656,752) by default.
- vsync is asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), which is [490,492) by default. vsync is line-aligned: it changes on the edge where x becomes 0.
- line_start is high for exactly the one clk following an edge where x went H_TOTAL-1→0.
- frame_start is high for exactly the one clk following an edge where (x,y) went (H_TOTAL-1,V_TOTAL-1)→(0,0).
- Arithmetic is 10-bit unsigned. Parameter sums must be ≤1023; default totals of 800 and 525 fit.

## Timing
- Reset values: div=0, x=0, y=0, video_on=0, hsync=vsync=!SYNC_POL (deasserted), line_start=0, frame_start=0, pix_tick=0.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous). No pulse is emitted on entry to or exit from reset.
- First clk edge after release: video_on becomes 1 because (0,0) is active; x and y hold at 0 until the first pix_tick.
- With CLK_DIV=2, the first pix_tick occurs in the 2nd cycle after release, and x becomes 1 on that edge.
- Output latency from counter change to output change is 0 clks (same edge). pix_tick leads the resulting x change by one edge.
- Default line period is 800 ticks = 1600 clk. Default frame period is 525 lines = 840000 clk.
- No reset-induced frame_start: the first frame_start occurs only after a full frame has elapsed.

## Test plan
- Reset check: hold rst_n=0, then release. Required: x=0, y=0, hsync=1, vsync=1, video_on=0, pulses 0 during reset; video_on=1 one clk after release; x=1 after 2 clks (CLK_DIV=2).
- Horizontal timing: run one line. Required: hsync low for exactly 192 clk starting when x becomes 656; line period 1600 clk; line_start one clk wide when x=0.
- Vertical timing: run one frame. Required: vsync low for exactly 3200 clk starting at (x=0,y=490); y reaches 524 then wraps; frame_start every 840000 clk, one clk wide.
- Active count: count clks with video_on=1 over one frame. Required: 614400 clk (307200 pixels × 2); video_on=0 at x=640 and at y=480.
- Mid-frame reset: pulse rst_n low at (x=300,y=200). Required: immediate return to reset values, no line_start/frame_start pulse, normal timing restarts from (0,0).
- CLK_DIV=1 build: required pix_tick=1 every cycle out of reset, line period 800 clk, hsync low for 96 clk.
